axi_r_delay_buf: RTL

// - Parametrised AXI read-response delay buffer, placed between the axi2mem R channel and the AXI master.
// - Successor to the fixed shift-register delay. It honours m_rready backpressure instead of requiring rready=1.
// - Supports configurable fixed or LFSR-random per-burst latency, and holds up to DEPTH beats in order.
// - Upstream is throttled through s_rready, so no request gating or queue-drain pause is needed to change latency.

---
 rtl/axi_r_delay_pkg.sv | 42 ++++
 rtl/axi_r_delay_lfsr.sv | 32 +++
 rtl/axi_r_delay_buf.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/axi_r_delay_pkg.sv
// Shared definitions for the AXI read-response delay buffer.
// Optional statistics counters are enabled by defining AXI_R_DELAY_STATS_EN.
package axi_r_delay_pkg;

    // Width of the free-running cycle timer and of every stored release time.
    localparam int TIMER_W = 16;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Width-independent part of a buffered beat. The id/data fields depend on
    // module parameters, so the buffer wraps this into its full entry type.
    typedef struct packed {
        logic [1:0]         resp;
        logic               last;
        logic [TIMER_W-1:0] rel_t;
    } entry_meta_t;

    // Latency for a burst head: min of 0 counts as 1, max below min counts as
    // min; random mode picks min + (rnd mod span).
    function automatic logic [7:0] lat_sanitise(
        input logic [7:0]  lat_min,
        input logic [7:0]  lat_max,
        input logic        rand_en,
        input logic [15:0] rnd
    );
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] span;
        logic [15:0] off;
        lo   = (lat_min == 8'd0) ? 8'd1 : lat_min;
        hi   = (lat_max < lo) ? lo : lat_max;
        span = {8'd0, hi} - {8'd0, lo} + 16'd1;
        off  = rnd % span;
        if (rand_en) begin
            lat_sanitise = 8'({8'd0, lo} + off);
        end else begin
            lat_sanitise = lo;
        end
    endfunction

endpackage

// File: rtl/axi_r_delay_lfsr.sv
// 16-bit Fibonacci LFSR used to draw per-burst random latencies.
// Advances every cycle; returns to SEED on reset. SEED must be nonzero.
module axi_r_delay_lfsr
    import axi_r_delay_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_r;
    logic        fb_s;

    // Feedback bit is the XOR of the tapped state bits.
    always_comb begin
        fb_s = ^(lfsr_r & LFSR_TAPS);
    end

    // Shift the state left every cycle, inserting the feedback bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= {lfsr_r[14:0], fb_s};
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/axi_r_delay_buf.sv
// AXI R-channel delay buffer: holds up to DEPTH beats in order and releases
// each one once the cycle timer reaches its stored release time. Upstream is
// throttled by s_rready, downstream honours m_rready backpressure.
// Define AXI_R_DELAY_STATS_EN to build the beat/stall statistics counters.
module axi_r_delay_buf
    import axi_r_delay_pkg::*;
#(
    parameter int          ID_WIDTH   = 4,
    parameter int          DATA_WIDTH = 512,
    parameter int          DEPTH      = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_WIDTH-1:0]     s_rid,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rlast,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    output logic [ID_WIDTH-1:0]     m_rid,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic [1:0]              m_rresp,
    output logic                    m_rlast,
    output logic                    m_rvalid,
    input  logic                    m_rready,
    input  logic [7:0]              cfg_lat_min,
    input  logic [7:0]              cfg_lat_max,
    input  logic                    cfg_rand_en,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [31:0]             o_stat_beats,
    output logic [31:0]             o_stat_stall
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        entry_meta_t           meta;
    } entry_t;

    entry_t                mem_r [DEPTH];
    logic [CW-1:0]         wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]         wr_ptr_nxt_s, rd_ptr_nxt_s, count_s, count_nxt_s;
    logic [TIMER_W-1:0]    timer_r, tnext_s, prev_rel_r, new_rel_s;
    logic                  burst_head_r;
    logic [15:0]           lfsr_s;
    logic [7:0]            lat_s;
    logic                  s_rready_s, push_s, pop_s;
    entry_t                new_entry_s, head_entry_s;
    logic [AW-1:0]         head_idx_s;
    logic                  head_due_s, hold_s, m_load_s, m_valid_nxt_s;
    logic                  m_rvalid_r, m_rlast_r;
    logic [ID_WIDTH-1:0]   m_rid_r;
    logic [DATA_WIDTH-1:0] m_rdata_r;
    logic [1:0]            m_rresp_r;

    axi_r_delay_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .lfsr (lfsr_s)
    );

    // Occupancy and handshakes; no room means no accept (no full pass-through).
    always_comb begin
        count_s    = wr_ptr_r - rd_ptr_r;
        s_rready_s = ~rst & (count_s != FULL_C);
        push_s     = s_rvalid & s_rready_s;
        pop_s      = m_rvalid_r & m_rready;
    end

    // Release time of the incoming beat: heads get T+lat, followers stream
    // at no earlier than the previous beat and never before T+1.
    always_comb begin
        lat_s   = lat_sanitise(cfg_lat_min, cfg_lat_max, cfg_rand_en, lfsr_s);
        tnext_s = timer_r + 16'd1;
        if (burst_head_r) begin
            new_rel_s = timer_r + {8'd0, lat_s};
        end else if ($signed(prev_rel_r - tnext_s) < 16'sd0) begin
            new_rel_s = tnext_s;
        end else begin
            new_rel_s = prev_rel_r;
        end
        new_entry_s.id         = s_rid;
        new_entry_s.data       = s_rdata;
        new_entry_s.meta.resp  = s_rresp;
        new_entry_s.meta.last  = s_rlast;
        new_entry_s.meta.rel_t = new_rel_s;
    end

    // Look ahead at next cycle's head so the outputs can be registered; a beat
    // written this cycle into an empty slot is forwarded from the write data.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r + CW'(push_s);
        rd_ptr_nxt_s = rd_ptr_r + CW'(pop_s);
        count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
        head_idx_s   = rd_ptr_nxt_s[AW-1:0];
        if (push_s && (head_idx_s == wr_ptr_r[AW-1:0])) begin
            head_entry_s = new_entry_s;
        end else begin
            head_entry_s = mem_r[head_idx_s];
        end
        head_due_s    = (count_nxt_s != ZERO_C) &&
                        ($signed(tnext_s - head_entry_s.meta.rel_t) >= 16'sd0);
        hold_s        = m_rvalid_r & ~m_rready;
        m_load_s      = ~hold_s & head_due_s;
        m_valid_nxt_s = hold_s | head_due_s;
    end

    // Timer, pointers and burst-head tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r      <= 16'd0;
            wr_ptr_r     <= ZERO_C;
            rd_ptr_r     <= ZERO_C;
            burst_head_r <= 1'b1;
            prev_rel_r   <= 16'd0;
        end else begin
            timer_r  <= tnext_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            if (push_s) begin
                burst_head_r <= s_rlast;
                prev_rel_r   <= new_rel_s;
            end
        end
    end

    // Beat storage; push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= new_entry_s;
        end
    end

    // Output register: holds while stalled, keeps last fields when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rvalid_r <= 1'b0;
            m_rid_r    <= {ID_WIDTH{1'b0}};
            m_rdata_r  <= {DATA_WIDTH{1'b0}};
            m_rresp_r  <= 2'd0;
            m_rlast_r  <= 1'b0;
        end else begin
            m_rvalid_r <= m_valid_nxt_s;
            if (m_load_s) begin
                m_rid_r   <= head_entry_s.id;
                m_rdata_r <= head_entry_s.data;
                m_rresp_r <= head_entry_s.meta.resp;
                m_rlast_r <= head_entry_s.meta.last;
            end
        end
    end

    assign s_rready = s_rready_s;
    assign m_rvalid = m_rvalid_r;
    assign m_rid    = m_rid_r;
    assign m_rdata  = m_rdata_r;
    assign m_rresp  = m_rresp_r;
    assign m_rlast  = m_rlast_r;
    assign o_count  = count_s;

`ifdef AXI_R_DELAY_STATS_EN
    logic [31:0] stat_beats_r, stat_stall_r;

    // Delivered-beat and stall-cycle counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats_r <= 32'd0;
            stat_stall_r <= 32'd0;
        end else begin
            if (pop_s) begin
                stat_beats_r <= stat_beats_r + 32'd1;
            end
            if (m_rvalid_r & ~m_rready) begin
                stat_stall_r <= stat_stall_r + 32'd1;
            end
        end
    end

    assign o_stat_beats = stat_beats_r;
    assign o_stat_stall = stat_stall_r;
`else
    assign o_stat_beats = 32'd0;
    assign o_stat_stall = 32'd0;
`endif

endmodule
